// File: rtl/rx_decision_slicer.sv
// 4-PAM decision slicer: picks one matched-filter sample per symbol at a programmable phase,
// slices it against a self-adjusting reference and tracks signal presence with a 2-state FSM.
module rx_decision_slicer #(
    parameter int AVG_LOG2 = 10,
    parameter int INIT_REF = 32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic [1:0]         phase_sel,
    input  logic signed [17:0] in,
    output logic [1:0]         sym_out,
    output logic signed [17:0] mapped_out,
    output logic signed [17:0] err_out,
    output logic               sym_valid,
    output logic signed [17:0] ref_level,
    output logic               locked
);

    localparam int ACCW    = 18 + AVG_LOG2;
    localparam int LOS_THR = INIT_REF >>> 3;
    localparam logic signed [19:0] MAX20 = 20'sd131071;
    localparam logic signed [19:0] MIN20 = -20'sd131072;

    typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

    function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
        if (v > MAX20) return 18'sh1ffff;
        if (v < MIN20) return 18'sh20000;
        return v[17:0];
    endfunction

    // Phase tracking / capture qualification
    logic [1:0] p_q, p_d, lat_q, lat_d;
    logic       armed_q, armed_d;
    logic       qual_sym, capture;

    always_comb begin
        qual_sym = sam_clk_en & sym_clk_en;
        p_d      = p_q;
        if (sam_clk_en) begin
            if (sym_clk_en)        p_d = 2'd0;
            else if (p_q != 2'd3)  p_d = p_q + 2'd1;
        end
        lat_d   = qual_sym ? phase_sel : lat_q;
        armed_d = armed_q | qual_sym;
        capture = sam_clk_en & armed_d & (p_d == lat_d);
    end

    // Decision against the reference in effect at capture time
    logic signed [17:0] ref_q;
    logic signed [19:0] x20, r20, a20, a3_20, lvl20, err20;
    logic signed [17:0] mapped_d, err_d;
    logic [1:0]         sym_d;

    always_comb begin
        x20   = {{2{in[17]}}, in};
        r20   = {{2{ref_q[17]}}, ref_q};
        a20   = r20 >>> 1;
        a3_20 = r20 + a20;
        if (x20 >= r20) begin
            sym_d = 2'b10;
            lvl20 = a3_20;
        end else if (x20 >= 20'sd0) begin
            sym_d = 2'b11;
            lvl20 = a20;
        end else if (x20 >= -r20) begin
            sym_d = 2'b01;
            lvl20 = -a20;
        end else begin
            sym_d = 2'b00;
            lvl20 = -a3_20;
        end
        mapped_d = sat18(lvl20);
        err20    = x20 - {{2{mapped_d[17]}}, mapped_d};
        err_d    = sat18(err20);
    end

    // Reference averaging: saturating |x| into a block accumulator
    logic [16:0]         abs_x;
    logic [ACCW-1:0]     acc_q, acc_sum;
    logic [AVG_LOG2-1:0] cnt_q;
    logic [17:0]         avg;
    logic                block_end, good_blk;

    always_comb begin
        if (!in[17])               abs_x = in[16:0];
        else if (in == 18'sh20000) abs_x = 17'h1ffff;
        else                       abs_x = 17'(-in);
        acc_sum   = acc_q + ACCW'(abs_x);
        avg       = 18'(acc_sum >> AVG_LOG2);
        block_end = (cnt_q == '1);
        good_blk  = (avg >= 18'(LOS_THR));
    end

    state_t state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACQ;
            ref_q   <= 18'(INIT_REF);
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (capture) begin
            cnt_q <= cnt_q + 1'b1;
            if (block_end) begin
                acc_q <= '0;
                if (good_blk) begin
                    ref_q   <= avg;
                    state_q <= TRACK;
                end else begin
                    // Loss of signal: fall back to the acquisition reference
                    ref_q   <= 18'(INIT_REF);
                    state_q <= ACQ;
                end
            end else begin
                acc_q <= acc_sum;
            end
        end
    end

    logic [1:0]         sym_q;
    logic signed [17:0] mapped_q, err_q;
    logic               vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q      <= 2'd0;
            lat_q    <= 2'd0;
            armed_q  <= 1'b0;
            vld_q    <= 1'b0;
            sym_q    <= 2'b00;
            mapped_q <= '0;
            err_q    <= '0;
        end else begin
            p_q     <= p_d;
            lat_q   <= lat_d;
            armed_q <= armed_d;
            vld_q   <= capture;
            if (capture) begin
                sym_q    <= sym_d;
                mapped_q <= mapped_d;
                err_q    <= err_d;
            end
        end
    end

    assign sym_out    = sym_q;
    assign mapped_out = mapped_q;
    assign err_out    = err_q;
    assign sym_valid  = vld_q;
    assign ref_level  = ref_q;
    assign locked     = (state_q == TRACK);

endmodule

// File: tb/tb_rx_decision_slicer.sv
// Randomized bench for rx_decision_slicer, checked against a symbol-level reference model.
module tb_rx_decision_slicer;

    localparam int AVG_LOG2 = 4;
    localparam int INIT_REF = 32768;
    localparam int BLK      = 1 << AVG_LOG2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sam_clk_en = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic [1:0]         phase_sel = 2'd0;
    logic signed [17:0] din = '0;
    logic [1:0]         sym_out;
    logic signed [17:0] mapped_out, err_out, ref_level;
    logic               sym_valid, locked;

    rx_decision_slicer #(.AVG_LOG2(AVG_LOG2), .INIT_REF(INIT_REF)) dut (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .phase_sel(phase_sel), .in(din), .sym_out(sym_out), .mapped_out(mapped_out),
        .err_out(err_out), .sym_valid(sym_valid), .ref_level(ref_level), .locked(locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_armed;
    int         m_idx, m_lat, m_ref;
    bit         m_locked;
    int         m_blk[$];
    logic [1:0] exp_sym;
    int         exp_map, exp_err;
    int         exp_vld, obs_vld;
    int         ramp_idx;

    function automatic int clamp18(input int v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int rnd18();
        return int'($urandom_range(262143)) - 131072;
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_idx = 0; m_lat = 0; m_ref = INIT_REF; m_locked = 0;
        m_blk.delete();
        exp_sym = 2'b00; exp_map = 0; exp_err = 0;
    endfunction

    function automatic void model_capture(input int x);
        int a, lvl, mag, sum;
        a = m_ref / 2;
        if (x >= m_ref)      begin exp_sym = 2'b10; lvl = m_ref + a;    end
        else if (x >= 0)     begin exp_sym = 2'b11; lvl = a;            end
        else if (x >= -m_ref) begin exp_sym = 2'b01; lvl = -a;          end
        else                 begin exp_sym = 2'b00; lvl = -(m_ref + a); end
        exp_map = clamp18(lvl);
        exp_err = clamp18(x - exp_map);
        exp_vld++;
        mag = (x < 0) ? -x : x;
        if (mag > 131071) mag = 131071;
        m_blk.push_back(mag);
        if (m_blk.size() == BLK) begin
            sum = 0;
            foreach (m_blk[i]) sum += m_blk[i];
            if (sum / BLK >= INIT_REF / 8) begin m_ref = sum / BLK; m_locked = 1; end
            else begin m_ref = INIT_REF; m_locked = 0; end
            m_blk.delete();
        end
    endfunction

    // One clock of stimulus; the model sees the same strobes the DUT does.
    task automatic step(input bit sam, input bit sym, input logic [1:0] ph, input int x);
        @(negedge clk);
        sam_clk_en = sam; sym_clk_en = sym; phase_sel = ph; din = 18'(x);
        if (sam) begin
            if (sym) begin m_idx = 0; m_lat = int'(ph); m_armed = 1; end
            else if (m_idx < 3) m_idx++;
            if (m_armed && m_idx == m_lat) model_capture(x);
        end
        @(posedge clk); #1;
        if (sym_valid === 1'b1) obs_vld++;
    endtask

    // Four samples; the value at the boundary-latched phase carries val (or a ramp).
    task automatic send_symbol(input logic [1:0] ph_b, input logic [1:0] ph_m,
                               input int val, input bit ramp, input bit idle);
        int x;
        for (int k = 0; k < 4; k++) begin
            if (ramp) x = ramp_idx++;
            else      x = (k == int'(ph_b)) ? val : rnd18();
            step(1'b1, k == 0, (k == 0) ? ph_b : ph_m, x);
            if (idle) step(1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)), rnd18());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sam_clk_en = 1'b1; sym_clk_en = 1'b1; din = 18'(rnd18());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; sam_clk_en = 1'b1; sym_clk_en = 1'b1; phase_sel = 2'd0;
        for (int c = 0; c < 4; c++) begin
            din = 18'(rnd18());
            @(posedge clk); #1;
            checks++;
            if (sym_out !== 2'b00 || mapped_out !== 18'sd0 || err_out !== 18'sd0 || sym_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got sym=%b map=%0d err=%0d vld=%b want all 0",
                         c, sym_out, mapped_out, err_out, sym_valid);
            end
            checks++;
            if (ref_level !== 18'(INIT_REF) || locked !== 1'b0) begin
                errors++;
                $display("FAIL reset_ref[%0d] got ref=%0d lock=%b want ref=%0d lock=0",
                         c, ref_level, locked, INIT_REF);
            end
        end
        @(negedge clk);
        reset = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0;
        model_reset();
    endtask

    task automatic test_phase();
        logic [1:0] pb[6] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
        logic [1:0] pm[6] = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0};
        int base, got;
        ramp_idx = 0;
        for (int s = 0; s < 6; s++) begin
            base = ramp_idx;
            send_symbol(pb[s], pm[s], 0, 1'b1, 1'b1);
            got = int'(err_out) + int'(mapped_out);
            checks++;
            if (got !== base + int'(pb[s])) begin
                errors++;
                $display("FAIL phase_pick[%0d] got sample=%0d want %0d", s, got, base + int'(pb[s]));
            end
            checks++;
            if (sym_out !== exp_sym || err_out !== 18'(exp_err)) begin
                errors++;
                $display("FAIL phase_model[%0d] got sym=%b err=%0d want sym=%b err=%0d",
                         s, sym_out, err_out, exp_sym, exp_err);
            end
        end
    endtask

    task automatic test_slice();
        int         xin[6]  = '{49152, 32768, 32767, -1, -32768, -32769};
        logic [1:0] xsym[6] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00};
        int         xerr[6] = '{0, -16384, 16383, 16383, -16384, 16383};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_symbol(2'd0, 2'($urandom_range(3)), xin[i], 1'b0, 1'b1);
            checks++;
            if (sym_out !== xsym[i] || err_out !== 18'(xerr[i])) begin
                errors++;
                $display("FAIL slice[%0d] in=%0d got sym=%b err=%0d want sym=%b err=%0d",
                         i, xin[i], sym_out, err_out, xsym[i], xerr[i]);
            end
        end
    endtask

    task automatic test_average();
        int v[4] = '{20000, -20000, 60000, -60000};
        do_reset();
        for (int i = 0; i < BLK; i++) send_symbol(2'd1, 2'd3, v[i % 4], 1'b0, 1'b1);
        checks++;
        if (ref_level !== 18'sd40000 || locked !== 1'b1) begin
            errors++;
            $display("FAIL avg_lock got ref=%0d lock=%b want ref=40000 lock=1", ref_level, locked);
        end
        for (int i = 0; i < 8; i++) send_symbol(2'd2, 2'd0, v[i % 4], 1'b0, 1'b0);
        do_reset();
        @(posedge clk); #1;
        checks++;
        if (ref_level !== 18'(INIT_REF) || locked !== 1'b0) begin
            errors++;
            $display("FAIL avg_reset got ref=%0d lock=%b want ref=%0d lock=0", ref_level, locked, INIT_REF);
        end
        // A fresh block must need all BLK captures again
        for (int i = 0; i < BLK - 1; i++) send_symbol(2'd0, 2'd1, 50000, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || ref_level !== 18'(INIT_REF)) begin
            errors++;
            $display("FAIL avg_restart got ref=%0d lock=%b want ref=%0d lock=0", ref_level, locked, INIT_REF);
        end
        send_symbol(2'd0, 2'd1, 50000, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b1 || ref_level !== 18'sd50000) begin
            errors++;
            $display("FAIL avg_relock got ref=%0d lock=%b want ref=50000 lock=1", ref_level, locked);
        end
    endtask

    task automatic test_los();
        for (int i = 0; i < BLK - 1; i++) send_symbol(2'd3, 2'd0, 1000, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b1 || ref_level !== 18'sd50000) begin
            errors++;
            $display("FAIL los_hold got ref=%0d lock=%b want ref=50000 lock=1", ref_level, locked);
        end
        send_symbol(2'd3, 2'd0, 1000, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || ref_level !== 18'(INIT_REF)) begin
            errors++;
            $display("FAIL los_drop got ref=%0d lock=%b want ref=%0d lock=0", ref_level, locked, INIT_REF);
        end
    endtask

    task automatic test_saturation();
        int         xin[2]  = '{131071, -131072};
        logic [1:0] xsym[2] = '{2'b10, 2'b00};
        int         xmap[2] = '{131071, -131072};
        do_reset();
        for (int i = 0; i < BLK; i++) send_symbol(2'd2, 2'd1, 131071, 1'b0, 1'b1);
        checks++;
        if (ref_level !== 18'sd131071 || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_ref got ref=%0d lock=%b want ref=131071 lock=1", ref_level, locked);
        end
        for (int i = 0; i < 2; i++) begin
            send_symbol(2'd2, 2'd1, xin[i], 1'b0, 1'b1);
            checks++;
            if (sym_out !== xsym[i] || mapped_out !== 18'(xmap[i]) || err_out !== 18'sd0) begin
                errors++;
                $display("FAIL sat_slice[%0d] got sym=%b map=%0d err=%0d want sym=%b map=%0d err=0",
                         i, sym_out, mapped_out, err_out, xsym[i], xmap[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int v;
        do_reset();
        for (int s = 0; s < 40; s++) begin
            v = (s < 20) ? rnd18() : int'($urandom_range(4000)) - 2000;
            send_symbol(2'($urandom_range(3)), 2'($urandom_range(3)), v, 1'b0, s[0]);
            checks++;
            if (sym_out !== exp_sym || mapped_out !== 18'(exp_map) || err_out !== 18'(exp_err)) begin
                errors++;
                $display("FAIL b2b_data[%0d] got sym=%b map=%0d err=%0d want sym=%b map=%0d err=%0d",
                         s, sym_out, mapped_out, err_out, exp_sym, exp_map, exp_err);
            end
            checks++;
            if (ref_level !== 18'(m_ref) || locked !== m_locked) begin
                errors++;
                $display("FAIL b2b_ref[%0d] got ref=%0d lock=%b want ref=%0d lock=%b",
                         s, ref_level, locked, m_ref, m_locked);
            end
        end
    endtask

    initial begin
        exp_vld = 0; obs_vld = 0; ramp_idx = 0;
        model_reset();
        test_reset();
        test_phase();
        test_slice();
        test_average();
        test_los();
        test_saturation();
        test_back_to_back();
        checks++;
        if (obs_vld !== exp_vld) begin
            errors++;
            $display("FAIL valid_pulses got %0d want %0d", obs_vld, exp_vld);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
